data_ram_bhw: RTL and testbench
===============================

// Module: data_ram_bhw
// PURPOSE
//  Byte-addressable little-endian data memory for the memory functional unit.
//  An internal 32-bit adder (add_32 function) forms the effective address as base + offset.
//  Supports byte, halfword and word stores, plus signed/unsigned byte and halfword loads.
//  Memory is written on the clock edge and read combinationally.
// PARAMETERS
//  MEM_BYTES  1024  storage size in bytes; power of two, >= 4
//  ADDR_LSB   10    log2(MEM_BYTES); effective-address bits used to index storage
// PORTS
//  clka         in   1   clock; all writes occur on its rising edge
//  rst          in   1   reset, asynchronous, active-high
//  addra        in   32  base address (rs1)
//  offa         in   32  address offset (sign-extended immediate)
//  dina         in   32  store data; the low byte/half/word is used
//  wea          in   1   1 = store, 0 = load
//  mem_u_b_h_w  in   3   [2]=unsigned load, [1:0]: 00 byte, 01 half, 10 word
//  douta        out  32  load data, combinational
//  eff_addr     out  32  effective address = addra + offa
// BEHAVIOUR
//  Adder:
//   - eff_addr = (addra + offa) mod 2^32.
//   - Carry-out is discarded.
//   - Fully combinational.
//  Indexing:
//   - Storage index = eff_addr[ADDR_LSB-1:0].
//   - Upper address bits are ignored, so accesses wrap modulo MEM_BYTES.
//  Alignment (macro absent):
//   - Halfword access clears eff_addr[0].
//   - Word access clears eff_addr[1:0].
//  Store, on rising clka with wea=1 and rst=0:
//   - Byte: writes dina[7:0].
//   - Half: writes dina[15:0], low byte at the lower address.
//   - Word: writes dina[31:0], byte0 at the lowest address.
//   - All other bytes are unchanged.
//  Load:
//   - douta is driven combinationally from the current storage and eff_addr.
//   - When wea=1, douta still shows the pre-write contents in the same cycle.
//   - Byte (000): sign-extended. Byte unsigned (100): zero-extended.
//   - Half (001): sign-extended. Half unsigned (101): zero-extended.
//   - Word (010 or 110): mem_u_b_h_w[2] is ignored.
//  Encoding 11 in [1:0] is treated as word for both loads and stores.
//  Write followed by a read of the same address on the next cycle returns the new data (no extra latency).
//  Reset:
//   - rst=1 asynchronously clears every storage byte to 0, so douta=0.
//   - Writes are ignored while rst=1.
//   - If reset is asserted during a store cycle, the clear wins.
// CONFIGURATION
//  RAM_B_MISALIGN_CHECK_EN, when defined:
//   - Adds output port misalign (1 bit).
//   - misalign=1 when a half access has eff_addr[0]=1, or a word access has eff_addr[1:0]!=0.
//   - While misalign=1: stores are suppressed and douta=0.
//   - No forced alignment is applied.
//  When undefined:
//   - The misalign port does not exist.
//   - Forced alignment applies as described under BEHAVIOUR.
// TESTING
//  1. rst pulse, then load word at 0x0 -> douta=0x00000000.
//  2. SW dina=0x8765_4321 at base=0x10, offa=0x4 -> eff_addr=0x14.
//     LW at 0x14 -> 0x87654321; LB at 0x14 -> 0x00000021; LB at 0x17 -> 0xFFFFFF87; LBU at 0x17 -> 0x00000087.
//  3. SH dina=0xFFFF_80AA at 0x20, then LH at 0x20 -> 0xFFFF80AA; LHU -> 0x000080AA.
//     SB 0x55 at 0x23, then LW at 0x20 -> 0x550080AA.
//  4. base=0xFFFF_FFFC, offa=0x8 -> eff_addr=0x4; SW 0xDEADBEEF, then LW at base=0x4, offa=0 -> 0xDEADBEEF.
//     Address MEM_BYTES+0x4 aliases to 0x4.
//  5. Async rst mid-cycle after stores -> douta=0 immediately, without a clock edge.
//     A store edge while rst=1 leaves the memory at 0.
//  6. Misaligned LW at 0x22:
//     - With the macro: misalign=1, douta=0, and a store there is dropped.
//     - Without the macro: the access reads 0x20.

Source files
------------

// File: rtl/data_ram_bhw.sv
// Byte-addressable little-endian data RAM with a base+offset address adder and sized, sign-aware loads.
// Optional `RAM_B_MISALIGN_CHECK_EN adds a misalign flag and suppresses unaligned accesses instead of forcing alignment.
module data_ram_bhw #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_LSB  = 10
) (
   input  logic        clka,
   input  logic        rst,
   input  logic [31:0] addra,
   input  logic [31:0] offa,
   input  logic [31:0] dina,
   input  logic        wea,
   input  logic [2:0]  mem_u_b_h_w,
`ifdef RAM_B_MISALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic [31:0] douta,
   output logic [31:0] eff_addr
);

   localparam int unsigned DW = 32;

   function automatic logic [DW-1:0] add_32(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DW-1:0];
   endfunction

   logic [7:0]          mem [MEM_BYTES];
   logic [ADDR_LSB-1:0] acc;
   logic [ADDR_LSB-1:0] idx0, idx1, idx2, idx3;
   logic                is_byte, is_half, is_word;
   logic                mis_c;
   logic                wr_en;
   logic                sgn;
   logic [7:0]          b0, b1, b2, b3;

   assign eff_addr = add_32(addra, offa);

   // Encoding 11 in the size field behaves as a word access
   assign is_byte = (mem_u_b_h_w[1:0] == 2'b00);
   assign is_half = (mem_u_b_h_w[1:0] == 2'b01);
   assign is_word = mem_u_b_h_w[1];
   assign sgn     = ~mem_u_b_h_w[2];

   always_comb begin
      acc   = eff_addr[ADDR_LSB-1:0];
      mis_c = 1'b0;
`ifdef RAM_B_MISALIGN_CHECK_EN
      mis_c = (is_half & acc[0]) | (is_word & (acc[1:0] != 2'b00));
`else
      if (is_half) acc[0]   = 1'b0;
      if (is_word) acc[1:0] = 2'b00;
`endif
   end

`ifdef RAM_B_MISALIGN_CHECK_EN
   assign misalign = mis_c;
`endif

   assign idx0  = acc;
   assign idx1  = acc + ADDR_LSB'(1);
   assign idx2  = acc + ADDR_LSB'(2);
   assign idx3  = acc + ADDR_LSB'(3);
   assign wr_en = wea & ~mis_c;

   // Storage: async clear dominates any store on the same edge
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MEM_BYTES; i++) mem[ADDR_LSB'(i)] <= 8'h00;
      end else if (wr_en) begin
         mem[idx0] <= dina[7:0];
         if (!is_byte) mem[idx1] <= dina[15:8];
         if (is_word) begin
            mem[idx2] <= dina[23:16];
            mem[idx3] <= dina[31:24];
         end
      end
   end

   assign b0 = mem[idx0];
   assign b1 = mem[idx1];
   assign b2 = mem[idx2];
   assign b3 = mem[idx3];

   // Load path: pre-write contents, sign/zero extended by access size
   always_comb begin
      douta = '0;
      if (!mis_c) begin
         if (is_byte)      douta = {{24{b0[7] & sgn}}, b0};
         else if (is_half) douta = {{16{b1[7] & sgn}}, b1, b0};
         else              douta = {b3, b2, b1, b0};
      end
   end

endmodule

// File: tb/tb_data_ram_bhw.sv
// Scoreboard bench for data_ram_bhw: directed ops queue expectations, a negedge monitor compares.
module tb_data_ram_bhw;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LW3 = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   logic        clka = 1'b0;
   logic        rst;
   logic [31:0] addra, offa, dina;
   logic        wea;
   logic [2:0]  mem_u_b_h_w;
   logic [31:0] douta, eff_addr;
`ifdef RAM_B_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   typedef struct {
      string       name;
      logic [31:0] d;
      logic [31:0] e;
      logic        m;
   } exp_t;

   exp_t q[$];
   logic chk_vld;
   int   total = 0;
   int   bad   = 0;

   data_ram_bhw dut (
      .clka(clka), .rst(rst), .addra(addra), .offa(offa), .dina(dina),
      .wea(wea), .mem_u_b_h_w(mem_u_b_h_w),
`ifdef RAM_B_MISALIGN_CHECK_EN
      .misalign(misalign),
`endif
      .douta(douta), .eff_addr(eff_addr)
   );

   always #5 clka = ~clka;

   task automatic op(input string name, input logic r, input logic we, input logic [2:0] f,
                     input logic [31:0] b, input logic [31:0] o, input logic [31:0] din,
                     input logic chk, input logic [31:0] ed, input logic [31:0] ee, input logic em);
      exp_t x;
      @(posedge clka);
      #1;
      rst = r; wea = we; mem_u_b_h_w = f; addra = b; offa = o; dina = din;
      chk_vld = chk;
      if (chk) begin
         x.name = name; x.d = ed; x.e = ee; x.m = em;
         q.push_back(x);
      end
   endtask

   // Monitor: sample between active edges
   initial begin
      exp_t x;
      forever begin
         @(negedge clka);
         if (chk_vld === 1'b1) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL underflow: monitor saw a check with no queued expectation");
            end else begin
               x = q.pop_front();
               if (douta !== x.d) begin
                  bad++;
                  $display("FAIL %s douta: got %h want %h", x.name, douta, x.d);
               end
               total++;
               if (eff_addr !== x.e) begin
                  bad++;
                  $display("FAIL %s eff_addr: got %h want %h", x.name, eff_addr, x.e);
               end
`ifdef RAM_B_MISALIGN_CHECK_EN
               total++;
               if (misalign !== x.m) begin
                  bad++;
                  $display("FAIL %s misalign: got %b want %b", x.name, misalign, x.m);
               end
`endif
            end
         end
      end
   end

   initial begin
      rst = 1'b1; wea = 1'b0; mem_u_b_h_w = LW; addra = '0; offa = '0; dina = '0; chk_vld = 1'b0;
      repeat (2) @(posedge clka);
      // 1: reset pulse then load word 0
      op("rst_pulse", 1, 0, LW, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      op("lw0_rst",   0, 0, LW, 32'h0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
      // 2: word store and sized loads
      op("sw14_pre",  0, 1, LW,  32'h10, 32'h4, 32'h87654321, 1, 32'h0, 32'h14, 0);
      op("lw14",      0, 0, LW,  32'h14, 32'h0, 32'h0, 1, 32'h87654321, 32'h14, 0);
      op("lb14",      0, 0, LB,  32'h14, 32'h0, 32'h0, 1, 32'h00000021, 32'h14, 0);
      op("lb17",      0, 0, LB,  32'h17, 32'h0, 32'h0, 1, 32'hFFFFFF87, 32'h17, 0);
      op("lbu17",     0, 0, LBU, 32'h17, 32'h0, 32'h0, 1, 32'h00000087, 32'h17, 0);
      op("lh16",      0, 0, LH,  32'h16, 32'h0, 32'h0, 1, 32'hFFFF8765, 32'h16, 0);
      op("lhu14",     0, 0, LHU, 32'h14, 32'h0, 32'h0, 1, 32'h00004321, 32'h14, 0);
      op("lwu14",     0, 0, LWU, 32'h14, 32'h0, 32'h0, 1, 32'h87654321, 32'h14, 0);
      op("lw3_14",    0, 0, LW3, 32'h14, 32'h0, 32'h0, 1, 32'h87654321, 32'h14, 0);
      op("lw_negoff", 0, 0, LW,  32'h18, 32'hFFFFFFFC, 32'h0, 1, 32'h87654321, 32'h14, 0);
      // 3: half store, byte merge
      op("sh20",      0, 1, LH,  32'h20, 32'h0, 32'hFFFF80AA, 0, 32'h0, 32'h20, 0);
      op("lh20",      0, 0, LH,  32'h20, 32'h0, 32'h0, 1, 32'hFFFF80AA, 32'h20, 0);
      op("lhu20",     0, 0, LHU, 32'h20, 32'h0, 32'h0, 1, 32'h000080AA, 32'h20, 0);
      op("sb23_pre",  0, 1, LB,  32'h23, 32'h0, 32'h12345655, 1, 32'h0, 32'h23, 0);
      op("lw20",      0, 0, LW,  32'h20, 32'h0, 32'h0, 1, 32'h550080AA, 32'h20, 0);
      // 4: adder wrap and storage aliasing
      op("sw_wrap",   0, 1, LW,  32'hFFFFFFFC, 32'h8, 32'hDEADBEEF, 1, 32'h0, 32'h4, 0);
      op("lw4",       0, 0, LW,  32'h4, 32'h0, 32'h0, 1, 32'hDEADBEEF, 32'h4, 0);
      op("lw404",     0, 0, LW,  32'h404, 32'h0, 32'h0, 1, 32'hDEADBEEF, 32'h404, 0);
      op("sw3_30",    0, 1, LW3, 32'h30, 32'h0, 32'h11223344, 0, 32'h0, 32'h30, 0);
      op("lw30",      0, 0, LW,  32'h30, 32'h0, 32'h0, 1, 32'h11223344, 32'h30, 0);
      // 6: misaligned accesses
`ifdef RAM_B_MISALIGN_CHECK_EN
      op("lw22_mis",  0, 0, LW,  32'h22, 32'h0, 32'h0, 1, 32'h0, 32'h22, 1);
      op("sw22_mis",  0, 1, LW,  32'h22, 32'h0, 32'hA5A5A5A5, 1, 32'h0, 32'h22, 1);
      op("lw20_kept", 0, 0, LW,  32'h20, 32'h0, 32'h0, 1, 32'h550080AA, 32'h20, 0);
      op("lh21_mis",  0, 0, LH,  32'h21, 32'h0, 32'h0, 1, 32'h0, 32'h21, 1);
      op("lb23_ok",   0, 0, LB,  32'h23, 32'h0, 32'h0, 1, 32'h00000055, 32'h23, 0);
`else
      op("lw22_algn", 0, 0, LW,  32'h22, 32'h0, 32'h0, 1, 32'h550080AA, 32'h22, 0);
      op("sw22_algn", 0, 1, LW,  32'h22, 32'h0, 32'hA5A5A5A5, 0, 32'h0, 32'h22, 0);
      op("lw20_new",  0, 0, LW,  32'h20, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 32'h20, 0);
      op("lh21_algn", 0, 0, LH,  32'h21, 32'h0, 32'h0, 1, 32'hFFFFA5A5, 32'h21, 0);
`endif
      // 5: async reset with no intervening clock edge, store while in reset
      op("rst_async", 1, 0, LW,  32'h14, 32'h0, 32'h0, 1, 32'h0, 32'h14, 0);
      op("sw_in_rst", 1, 1, LW,  32'h14, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 32'h14, 0);
      op("lw14_post", 0, 0, LW,  32'h14, 32'h0, 32'h0, 1, 32'h0, 32'h14, 0);
      op("lw4_post",  0, 0, LW,  32'h4, 32'h0, 32'h0, 1, 32'h0, 32'h4, 0);
      op("idle",      0, 0, LW,  32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      repeat (2) @(posedge clka);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
